cache_refill: RTL

CACHE_REFILL -- requirements
Module: cache_refill

---
 rtl/cache_refill_if.sv | 42 ++++
 rtl/cache_refill.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cache_refill_if.sv
// Bundle of the miss, memory-read, return-beat, data-array and tag-array signals
// exchanged between a cache line refill engine and its surroundings.
interface cache_refill_if #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 32
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic                miss_req_i;
    logic [ADDR_W-1:0]   miss_addr_i;
    logic                busy_o;
    logic                rd_req_o;
    logic [ADDR_W-1:0]   rd_addr_o;
    logic                rd_rdy_i;
    logic                ret_valid_i;
    logic                ret_last_i;
    logic [DATA_W-1:0]   ret_data_i;
    logic [INDEX_W-1:0]  index_o;
    logic [OFFSET_W-1:0] offset_o;
    logic [3:0]          wr_en_o;
    logic [DATA_W-1:0]   wr_data_o;
    logic                tag_wr_o;
    logic [TAG_W-1:0]    tag_o;
    logic                crit_valid_o;
    logic [DATA_W-1:0]   crit_data_o;
    logic                done_o;
    logic                err_o;

    modport slave (
        input  miss_req_i, miss_addr_i, rd_rdy_i, ret_valid_i, ret_last_i, ret_data_i,
        output busy_o, rd_req_o, rd_addr_o, index_o, offset_o, wr_en_o, wr_data_o,
               tag_wr_o, tag_o, crit_valid_o, crit_data_o, done_o, err_o
    );

    modport master (
        output miss_req_i, miss_addr_i, rd_rdy_i, ret_valid_i, ret_last_i, ret_data_i,
        input  busy_o, rd_req_o, rd_addr_o, index_o, offset_o, wr_en_o, wr_data_o,
               tag_wr_o, tag_o, crit_valid_o, crit_data_o, done_o, err_o
    );
endinterface

// File: rtl/cache_refill.sv
// Cache line refill engine: issues one line read per miss, writes the four
// returned beats into the data array, forwards the critical word and updates the tag.
module cache_refill #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    cache_refill_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_cnt;
    logic                r_busy;
    logic                r_rd_req;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_tag_wr;
    logic                r_done;
    logic                r_err;

    logic                w_beat;
    logic                w_cnt_last;
    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [1:0]          w_crit_sel;
    logic [OFFSET_W-1:0] w_offset;

    assign w_beat     = (r_state == ST_RECV) && bus.ret_valid_i;
    assign w_cnt_last = (r_cnt == 2'd3);
    assign w_index    = r_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign w_tag      = r_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign w_crit_sel = r_addr[3:2];
    assign w_offset   = OFFSET_W'({r_cnt, 2'b00});

    // Refill sequencer; control outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_cnt     <= 2'd0;
            r_busy    <= 1'b0;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
            r_tag_wr  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.miss_req_i) begin
                        r_state   <= ST_REQ;
                        r_addr    <= bus.miss_addr_i;
                        r_busy    <= 1'b1;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= {bus.miss_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    end
                end
                ST_REQ: begin
                    if (bus.rd_rdy_i) begin
                        r_state   <= ST_RECV;
                        r_cnt     <= 2'd0;
                        r_rd_req  <= 1'b0;
                        r_rd_addr <= '0;
                    end
                end
                ST_RECV: begin
                    if (bus.ret_valid_i) begin
                        r_cnt <= r_cnt + 2'd1;
                        // A fourth beat ends the line even without last; last on an earlier beat is short.
                        if (bus.ret_last_i || w_cnt_last) begin
                            r_state  <= ST_DONE;
                            r_tag_wr <= 1'b1;
                            r_done   <= 1'b1;
                            if (bus.ret_last_i != w_cnt_last) begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= 2'd0;
                    r_busy   <= 1'b0;
                    r_tag_wr <= 1'b0;
                    r_done   <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= 2'd0;
                    r_busy    <= 1'b0;
                    r_rd_req  <= 1'b0;
                    r_rd_addr <= '0;
                    r_tag_wr  <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    // Data-array write port and critical-word forward follow the return beat in the same cycle.
    always_comb begin
        bus.wr_en_o      = 4'b0000;
        bus.wr_data_o    = '0;
        bus.offset_o     = '0;
        bus.index_o      = '0;
        bus.crit_valid_o = 1'b0;
        bus.crit_data_o  = '0;
        if (w_beat) begin
            bus.wr_en_o   = 4'b1111;
            bus.wr_data_o = bus.ret_data_i;
            bus.offset_o  = w_offset;
            bus.index_o   = w_index;
            if (r_cnt == w_crit_sel) begin
                bus.crit_valid_o = 1'b1;
                bus.crit_data_o  = bus.ret_data_i;
            end else begin
                bus.crit_valid_o = 1'b0;
                bus.crit_data_o  = '0;
            end
        end else if (r_state == ST_DONE) begin
            bus.index_o = w_index;
        end else begin
            bus.index_o = '0;
        end
    end

    // Tag value is only presented while the tag write strobe is up.
    always_comb begin
        bus.tag_o = '0;
        if (r_tag_wr) begin
            bus.tag_o = w_tag;
        end else begin
            bus.tag_o = '0;
        end
    end

    assign bus.busy_o    = r_busy;
    assign bus.rd_req_o  = r_rd_req;
    assign bus.rd_addr_o = r_rd_addr;
    assign bus.tag_wr_o  = r_tag_wr;
    assign bus.done_o    = r_done;
    assign bus.err_o     = r_err;
endmodule
